// File: rtl/forest_pkg.sv
// forest_pkg: shared FSM state type and default sizing for the node memory arbiter.
package forest_pkg;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_IDX_W   = 3;
    localparam int DEF_DATA_W  = 8;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after rr_ptr.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               any_req
);
    logic [PTR_W-1:0] j;
    // Scanning from the far end lets the closest request to rr_ptr overwrite the rest.
    always_comb begin
        winner = '0;
        j      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[j]) winner = j;
        end
    end
    assign any_req = |req;
endmodule

// File: rtl/node_mem_arbiter.sv
// node_mem_arbiter: round-robin sharing of one node memory among branch-stage requesters,
// one read in flight at a time.
module node_mem_arbiter
    import forest_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [DATA_W-1:0]        resp_data,
    input  logic                     mem_rdy,
    output logic                     mem_rd_en,
    output logic [IDX_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]        mem_rd_data,
    output logic                     busy
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    arb_state_t       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_id;
    logic [PTR_W-1:0] winner;
    logic [IDX_W-1:0] idx;
    logic             any_req;
    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            idx        <= '0;
            resp_data  <= '0;
            resp_valid <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    grant_id <= winner;
                    idx      <= req_idx[int'(winner)*IDX_W +: IDX_W];
                    rr_ptr   <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: if (mem_rdy) state <= WAIT;
                WAIT: begin
                    resp_data  <= mem_rd_data;
                    resp_valid <= NUM_REQ'(1) << grant_id;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Memory-side outputs decode straight from state/latched index, so requests never reach them combinationally.
    assign mem_rd_en = state == ISSUE;
    assign mem_addr  = idx;
    assign busy      = state != IDLE;
endmodule

// File: tb/tb_node_mem_arbiter.sv
// tb_node_mem_arbiter: directed vector table plus randomized run against a transaction-level model.
module tb_node_mem_arbiter;
    localparam int N  = 4;
    localparam int IW = 3;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*IW-1:0] req_idx = '0;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_data;
    logic            mem_rdy = 1'b1;
    logic            mem_rd_en;
    logic [IW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rd_data = '0;
    logic            busy;

    always #5 clk = ~clk;

    node_mem_arbiter #(.NUM_REQ(N), .IDX_W(IW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_idx     (req_idx),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .mem_rdy     (mem_rdy),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .busy        (busy)
    );

    logic [DW-1:0] mem [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hA7, 8'h66, 8'h77};

    // Memory returns data one cycle after an accepted read and garbage otherwise.
    always @(posedge clk) mem_rd_data <= (mem_rd_en && mem_rdy) ? mem[mem_addr] : DW'($urandom);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: edge numbers of grant and memory acceptance.
    bit            rand_on = 1'b0;
    int            cyc, a_e, m_id, m_ptr;
    bit            m_act;
    logic [IW-1:0] m_addr;
    logic [DW-1:0] last_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; m_act = 0; m_ptr = 0; m_id = 0; a_e = -1; m_addr = '0; last_data = '0;
        end else begin
            cyc++;
            if (!m_act) begin
                if (req_valid != 0) begin
                    for (int k = 0; k < N; k++)
                        if (req_valid[(m_ptr + k) % N]) begin
                            m_id = (m_ptr + k) % N;
                            break;
                        end
                    m_addr = req_idx[m_id*IW +: IW];
                    m_ptr  = (m_id + 1) % N;
                    m_act  = 1;
                    a_e    = -1;
                end
            end else if (a_e < 0) begin
                if (mem_rdy) a_e = cyc;
            end else if (cyc == a_e + 1) begin
                last_data = mem[m_addr];
            end else if (cyc == a_e + 2) begin
                m_act = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] er;
        er = (m_act && a_e >= 0 && cyc == a_e + 1) ? N'(1) << m_id : '0;
        if (rand_on && rst_n) begin
            check("rnd_resp_valid", resp_valid, er);
            check("rnd_busy", busy, m_act);
            check("rnd_rd_en", mem_rd_en, m_act && a_e < 0);
            if (m_act && a_e < 0) check("rnd_addr", mem_addr, m_addr);
            check("rnd_resp_data", resp_data, last_data);
        end
    end

    typedef struct {
        logic [N-1:0]    req;
        logic [N*IW-1:0] idx;
        logic [N*IW-1:0] idx2;
        int              stall;
        logic [N-1:0]    exp_resp;
        logic [IW-1:0]   exp_addr;
        logic [DW-1:0]   exp_data;
        string           tag;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int lat = 0, k = 0;
        bit done = 0, chg = 0;
        @(negedge clk);
        req_valid = v.req;
        req_idx   = v.idx;
        mem_rdy   = (v.stall == 0);
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
            if (mem_rd_en) begin
                k++;
                if (k == 1) check({v.tag, "_en_lat"}, lat, 1);
                check({v.tag, "_addr"}, mem_addr, v.exp_addr);
                mem_rdy = k > v.stall;
            end else if (k > 0 && resp_valid == 0 && !chg) begin
                req_idx = v.idx2;
                chg = 1;
            end
            if (resp_valid != 0) done = 1;
        end
        check({v.tag, "_lat"}, lat, 3 + v.stall);
        check({v.tag, "_resp_valid"}, resp_valid, v.exp_resp);
        check({v.tag, "_resp_data"}, resp_data, v.exp_data);
        @(negedge clk);
        req_valid = '0;
        mem_rdy   = 1'b1;
        check({v.tag, "_strobe_len"}, resp_valid, 0);
        check({v.tag, "_data_hold"}, resp_data, v.exp_data);
    endtask

    vec_t tbl[10];
    vec_t post_rst;
    bit [N-1:0] pend;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b1111, 12'h8D1, 12'h8D1, 0, 4'b0001, 3'd1, 8'h22, "rr0"};
        tbl[1] = '{4'b1111, 12'h8D1, 12'h8D1, 0, 4'b0010, 3'd2, 8'h33, "rr1"};
        tbl[2] = '{4'b1111, 12'h8D1, 12'h8D1, 0, 4'b0100, 3'd3, 8'h44, "rr2"};
        tbl[3] = '{4'b1111, 12'h8D1, 12'h8D1, 0, 4'b1000, 3'd4, 8'h55, "rr3"};
        tbl[4] = '{4'b1111, 12'h8D1, 12'h8D1, 0, 4'b0001, 3'd1, 8'h22, "rr4"};
        tbl[5] = '{4'b1000, 12'h8D1, 12'h8D1, 0, 4'b1000, 3'd4, 8'h55, "wrap3"};
        tbl[6] = '{4'b1001, 12'h8D1, 12'h8D1, 0, 4'b0001, 3'd1, 8'h22, "wrap0"};
        tbl[7] = '{4'b0001, 12'h005, 12'h005, 0, 4'b0001, 3'd5, 8'hA7, "single"};
        tbl[8] = '{4'b0001, 12'h005, 12'h005, 4, 4'b0001, 3'd5, 8'hA7, "stall"};
        tbl[9] = '{4'b0010, 12'h010, 12'h030, 0, 4'b0010, 3'd2, 8'h33, "idxchg"};
        post_rst = '{4'b1111, 12'h8D1, 12'h8D1, 0, 4'b0001, 3'd1, 8'h22, "post_rst"};

        repeat (3) @(negedge clk);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // Reset while waiting on memory data must drop the transaction silently.
        @(negedge clk);
        req_valid = 4'b0100;
        req_idx   = 12'h0C0;
        mem_rdy   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("wait_busy", busy, 1);
        check("wait_rd_en", mem_rd_en, 0);
        rst_n = 1'b0;
        #1;
        check("arst_resp_valid", resp_valid, 0);
        check("arst_resp_data", resp_data, 0);
        check("arst_rd_en", mem_rd_en, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_busy", busy, 0);
        req_valid = '0;
        @(negedge clk);
        check("arst_no_resp0", resp_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_no_resp1", resp_valid, 0);
        check("arst_idle", busy, 0);
        run_vec(post_rst);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        rand_on = 1'b1;
        pend    = '0;
        repeat (2000) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    req_valid[i] = 1'b0;
                    pend[i] = 1'b0;
                end else if (resp_valid[i]) begin
                    pend[i] = 1'b1;
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_idx[i*IW +: IW] = IW'($urandom);
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                int j;
                j = $urandom_range(0, N - 1);
                req_idx[j*IW +: IW] = IW'($urandom);
            end
            mem_rdy = $urandom_range(0, 3) != 0;
        end
        rand_on = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/node_mem_arbiter.md
NODE_MEM_ARBITER -- requirements
Module: node_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of branch-stage requesters sharing one node memory.
REQ-002 SHALL have parameter IDX_W, default 3: node index width.
REQ-003 SHALL have parameter DATA_W, default 8: node word width ({feature index, threshold}).
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ: per-requester read request, held until its resp_valid.
REQ-007 SHALL have port req_idx, input, NUM_REQ*IDX_W: per-requester node index; slice i is requester i.
REQ-008 SHALL have port resp_valid, output, NUM_REQ: one-cycle response strobe to the granted requester.
REQ-009 SHALL have port resp_data, output, DATA_W: node word, valid only while some resp_valid bit is 1.
REQ-010 SHALL have port mem_rdy, input, 1: memory accepts a read this cycle.
REQ-011 SHALL have port mem_rd_en, output, 1: read strobe.
REQ-012 SHALL have port mem_addr, output, IDX_W: read address.
REQ-013 SHALL have port mem_rd_data, input, DATA_W: read data, valid exactly one cycle after an accepted read (mem_rd_en && mem_rdy).
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP, with one transaction outstanding at a time.
REQ-016 IDLE SHALL remain in IDLE when req_valid == 0; otherwise register winner grant_id and its req_idx, then go to ISSUE.
REQ-017 Winner SHALL be the first set req_valid bit at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-018 On grant, rr_ptr SHALL become (winner+1) mod NUM_REQ.
REQ-019 ISSUE SHALL drive mem_rd_en=1 and mem_addr=latched index; it SHALL stay in ISSUE while mem_rdy=0 and go to WAIT on the cycle mem_rdy=1.
REQ-020 WAIT SHALL capture mem_rd_data into the response register and go to RESP.
REQ-021 RESP SHALL drive resp_valid[grant_id]=1 and resp_data=captured word for exactly one cycle, then go to IDLE.
REQ-022 Latency SHALL be 3 cycles from request sampled in IDLE to resp_valid when mem_rdy=1, plus one cycle per cycle mem_rdy=0 in ISSUE.
REQ-023 All outputs SHALL be registered or decoded only from state registers; there SHALL be no combinational path from req_valid to any output.
REQ-024 Changes to req_valid/req_idx after grant SHALL NOT affect the in-flight transaction; the index is latched at grant.
REQ-025 A requester SHALL deassert req_valid in the cycle after its resp_valid; a requester that is still high in IDLE is treated as a new request.
REQ-026 Simultaneous requests SHALL be served one per transaction in round-robin order; no requester waits more than NUM_REQ-1 transactions.
REQ-027 resp_data SHALL hold its last value when no resp_valid bit is set.

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE, rr_ptr=0, grant_id=0, latched index=0, resp_data=0, resp_valid=0, mem_rd_en=0, mem_addr=0, busy=0.
REQ-029 Reset mid-transaction SHALL abort the transaction with no resp_valid issued; requesters re-request after reset.

Structure
REQ-030 Shared package forest_pkg SHALL hold arb_state_t (IDLE/ISSUE/WAIT/RESP) and the default NUM_REQ/IDX_W/DATA_W constants.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req vector and rr_ptr; outputs winner index and any_req), purely combinational.

Verification
REQ-032 Single request: req_valid=4'b0001, req_idx[0]=3'd5, mem_rdy=1, mem returns 8'hA7 -> mem_rd_en with mem_addr=5 one cycle after request; resp_valid=4'b0001 with resp_data=8'hA7 three cycles after request.
REQ-033 Round robin: req_valid=4'b1111 held (each requester drops after its strobe, then re-raises) -> grants 0,1,2,3,0 in order.
REQ-034 Pointer wrap: after requester 3 is served, req_valid=4'b1001 -> requester 0 granted before 3.
REQ-035 Memory stall: mem_rdy=0 for 4 cycles during ISSUE -> mem_rd_en/mem_addr held stable; resp_valid arrives 4 cycles later than in REQ-032.
REQ-036 Index change after grant: req_idx[1] changes 2->6 while in WAIT -> mem_addr stayed at 2 and resp_data is the word at address 2.
REQ-037 Reset in WAIT: rst_n low for 1 cycle -> all outputs 0 immediately, no resp_valid, next grant goes to requester 0.
